// File: rtl/elastic_pipeline.sv
// Elastic valid/ready register pipeline with collapsing bubbles,
// synchronous flush and a registered occupancy count.
module elastic_pipeline #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("elastic_pipeline: DEPTH must be 2..8");
  end

  logic [DEPTH-1:0]  r_v;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [CW-1:0]     r_count;

  logic [DEPTH-1:0]  w_rdy;
  logic [DEPTH-1:0]  w_ld;
  logic [DEPTH-1:0]  w_v_nxt;
  logic              w_take;
  logic [CW-1:0]     w_cnt_nxt;

  // Backward ready chain, stage load enables and next valid/count
  always_comb begin
    w_rdy     = '0;
    w_ld      = '0;
    w_v_nxt   = r_v;
    w_take    = 1'b0;
    w_cnt_nxt = '0;
    w_rdy[DEPTH-1] = ~r_v[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      w_rdy[i] = ~r_v[i] | w_rdy[i+1];
    end
    w_take = in_valid & w_rdy[0] & ~flush;
    w_ld   = w_rdy & {DEPTH{~flush}};
    if (flush) begin
      w_v_nxt = '0;
    end else begin
      if (w_rdy[0]) w_v_nxt[0] = w_take;
      for (int i = 1; i < DEPTH; i++) begin
        if (w_rdy[i]) w_v_nxt[i] = r_v[i-1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_v_nxt[i]);
    end
  end

  // Valid bits and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v     <= '0;
      r_count <= '0;
    end else begin
      r_v     <= w_v_nxt;
      r_count <= w_cnt_nxt;
    end
  end

  // Data registers move only with a real word; bubbles leave stale data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      if (w_ld[0] && w_take) r_data[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (w_ld[i] && r_v[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed self-checking bench for elastic_pipeline (DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_elastic_pipeline;

  localparam int DW = 32;
  localparam int DP = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [2:0]    count;

  int n_chk = 0;
  int n_err = 0;

  elastic_pipeline #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_ov",  32'(out_valid), 0);
    chk("rst_cnt", 32'(count),     0);
    chk("rst_od",  out_data,       0);
    chk("rst_ir",  32'(in_ready),  1);
    tick();
    tick();
    rst = 1'b0;

    // Streaming: first word after 4th edge, then one per cycle
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e < 4) begin
        chk("str_ov0", 32'(out_valid), 0);
        chk("str_cnt", 32'(count), 32'(e));
      end else begin
        chk("str_ov1", 32'(out_valid), 1);
        chk("str_od",  out_data, 32'(4*(e-4)));
        chk("str_cnt", 32'(count), 4);
        chk("str_ir",  32'(in_ready), 1);
      end
      in_data = in_data + 32'h4;
    end

    // Output stall for 6 cycles: 32..44 in flight, 48 waiting
    out_ready = 1'b0;
    #1;
    chk("stl_ir0", 32'(in_ready), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stl_od",  out_data, 32'd32);
      chk("stl_cnt", 32'(count), 4);
      chk("stl_ir",  32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_ir", 32'(in_ready), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rel_od",  out_data, 32'(36 + 4*k));
      chk("rel_cnt", 32'(count), 4);
      in_data = in_data + 32'h4;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drn_od", out_data, 32'(56 + 4*k));
    end
    tick();
    chk("drn_ov",  32'(out_valid), 0);
    chk("drn_cnt", 32'(count), 0);

    // Single word collapses through bubbles while output stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h10;
    tick();
    in_valid = 1'b0;
    chk("col_ir1", 32'(in_ready), 1);
    tick();
    tick();
    tick();
    chk("col_ov",  32'(out_valid), 1);
    chk("col_od",  out_data, 32'h10);
    chk("col_cnt", 32'(count), 1);
    chk("col_ir",  32'(in_ready), 1);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'(32'h11 + k);
      tick();
      chk("fil_cnt", 32'(count), 32'(2 + k));
    end
    in_valid = 1'b0;
    chk("fil_ir", 32'(in_ready), 0);
    chk("fil_od", out_data, 32'h10);

    // Empty, then refill with 0x20..0x2C for the flush test
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("emp_cnt", 32'(count), 0);
    chk("emp_ov",  32'(out_valid), 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'(32'h20 + 4*k);
      tick();
    end
    chk("ful_cnt", 32'(count), 4);
    chk("ful_od",  out_data, 32'h20);
    chk("ful_ov",  32'(out_valid), 1);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h99;
    #1;
    chk("fl_ir", 32'(in_ready), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_cnt", 32'(count), 0);
    chk("fl_ov",  32'(out_valid), 0);
    for (int k = 0; k < 4; k++) tick();
    chk("fl_none", 32'(out_valid), 0);
    chk("fl_cnt2", 32'(count), 0);

    // Three words in flight, then mid-cycle async reset
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'(32'h30 + 4*k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mr_cnt", 32'(count), 3);
    chk("mr_ov",  32'(out_valid), 1);
    chk("mr_od",  out_data, 32'h30);
    #2 rst = 1'b1;
    #1;
    chk("ar_ov",  32'(out_valid), 0);
    chk("ar_cnt", 32'(count), 0);
    chk("ar_od",  out_data, 0);
    chk("ar_ir",  32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 32'h77;
    tick();
    chk("ar_hold", 32'(count), 0);
    rst       = 1'b0;
    in_data   = 32'h40;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pr_ov0", 32'(out_valid), 0);
    tick();
    chk("pr_ov1", 32'(out_valid), 0);
    tick();
    chk("pr_ov", 32'(out_valid), 1);
    chk("pr_od", out_data, 32'h40);
    chk("pr_cnt", 32'(count), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/elastic_pipeline.md
ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 Parameter DATA_W, default 32, width of the data word.
REQ-002 Parameter DEPTH, default 4, number of register stages (legal range 2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word present on in_data.
REQ-006 in_ready  output  1  pipeline accepts in_data this cycle (backpressure toward producer).
REQ-007 in_data  input  DATA_W  upstream word.
REQ-008 out_valid  output  1  last stage holds a valid word.
REQ-009 out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-010 out_data  output  DATA_W  word held in the last stage.
REQ-011 flush  input  1  synchronous discard of all in-flight words.
REQ-012 count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-013 Each stage i (0 = input side, DEPTH-1 = output side) SHALL hold a valid bit v[i] and a DATA_W data register.
REQ-014 Ready SHALL propagate backward combinationally: r[DEPTH-1] = ~v[DEPTH-1] | out_ready; r[i] = ~v[i] | r[i+1] for i < DEPTH-1.
REQ-015 in_ready SHALL equal r[0] & ~flush.
REQ-016 Input transfer occurs on a rising edge where in_valid & in_ready; the word loads into stage 0.
REQ-017 Output transfer occurs on a rising edge where out_valid & out_ready; out_valid = v[DEPTH-1], out_data = stage DEPTH-1 data.
REQ-018 Stage i+1 SHALL load stage i when r[i+1] is high; v[i+1] takes v[i]; a bubble (v=0) moves forward like a word.
REQ-019 A stage with r[i] low SHALL hold its valid bit and data unchanged (stall).
REQ-020 Bubbles SHALL collapse: an empty stage accepts from upstream even while the output is stalled.
REQ-021 Latency with no stall: a word accepted at edge N SHALL be on out_data with out_valid high immediately after edge N+DEPTH-1 (DEPTH edges including the acceptance edge).
REQ-022 Throughput SHALL be one word per cycle when in_valid and out_ready stay high.
REQ-023 Words SHALL leave in acceptance order; no word is dropped or duplicated except by flush or reset.
REQ-024 Data registers SHALL load only when their stage loads; stages loaded with a bubble MAY keep stale data, but out_data SHALL be ignored when out_valid is low.
REQ-025 flush high at an edge: an output transfer in that cycle still completes; then all v[i] SHALL clear; no input is accepted (in_ready low).
REQ-026 count SHALL equal the number of set v[i] bits, registered, updated every edge; range 0..DEPTH.
REQ-027 Full (count = DEPTH) with out_ready low: in_ready SHALL be low; with out_ready high: in_ready SHALL be high and count stays DEPTH after a simultaneous in/out transfer.
REQ-028 Empty (count = 0): out_valid SHALL be low; in_ready SHALL be high unless flush.

Reset
REQ-029 rst high SHALL immediately (without a clock edge) clear all v[i], all data registers to 0, and count to 0; out_valid low, out_data 0.
REQ-030 While rst high, in_ready SHALL be driven per REQ-015 on the cleared state, but no state changes at clock edges.
REQ-031 rst asserted mid-stream SHALL discard all in-flight words; after release the first accepted word follows REQ-021 latency.

Verification
REQ-032 Reset then stream in_data 0x0,0x4,0x8,... with in_valid=1, out_ready=1 (DEPTH=4) -> first out_valid with out_data=0x0 after the 4th edge, then 0x4,0x8,... one per cycle.
REQ-033 Stream as above, drop out_ready for 6 cycles -> count saturates at 4, in_ready low, out_data frozen; on release no word lost or repeated.
REQ-034 Single word 0x10 then in_valid=0, out_ready=0 -> word collapses to stage 3, count=1, in_ready stays high; three more words fill count to 4.
REQ-035 Pipeline full (0x20..0x2C), assert flush with out_ready=1 for one cycle -> 0x20 consumed that cycle, count=0 next cycle, out_valid low, in_data presented during flush not accepted.
REQ-036 Assert rst between edges with 3 words in flight -> out_valid, count, out_data go 0 before next edge; after release, word 0x40 emerges 4 edges after acceptance.
